// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer and its instruction decoder.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned CAUSE_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CLS_R      = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } op_cls_t;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_ILLEGAL    = 2'b01,
    CAUSE_FETCH_TO   = 2'b10,
    CAUSE_DATA_TO    = 2'b11
  } trap_cause_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic PC_SEL_PLUS4  = 1'b0;
  localparam logic PC_SEL_BRANCH = 1'b1;
  localparam logic WB_SEL_ALU    = 1'b0;
  localparam logic WB_SEL_MDR    = 1'b1;
  localparam logic ADDR_SEL_PC   = 1'b0;
  localparam logic ADDR_SEL_ALU  = 1'b1;

  // Unified memory port request payload.
  typedef struct packed {
    logic req;
    logic we;
    logic addr_sel;
  } mem_ctl_t;

  // True for the four opcodes the core implements.
  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  // Opcode class; only meaningful when is_legal(op) holds.
  function automatic op_cls_t op_class(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_R;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags the cycle on which the wait budget runs out.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = (MEM_TIMEOUT == 0) ? CW'(0) : CW'(MEM_TIMEOUT - 1);
  localparam logic ENABLE = (MEM_TIMEOUT != 0);

  logic [CW-1:0] cnt;

  // Wait counter: cleared between requests, holds at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expires on the MEM_TIMEOUT-th consecutive unanswered request cycle.
  assign expired = ENABLE && count_en && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared memory port.
module multicycle_seq
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ir_we,
  output logic                mdr_we,
  output logic                rf_we,
  output logic                wb_sel,
  output logic                pc_we,
  output logic                pc_sel,
  output logic                busy,
  output logic                trap,
  output logic [CAUSE_W-1:0]  trap_cause,
  output logic [CNT_W-1:0]    instret
);

  state_t      state, state_next;
  op_cls_t     cls, cls_next;
  logic [CNT_W-1:0] instret_q, instret_next;
  logic        trap_q, trap_next;
  trap_cause_t cause_q, cause_next;
  mem_ctl_t    mem_ctl;
  logic        retire;
  logic        mem_phase;
  logic        wait_expired;

  assign mem_phase = (state == ST_FETCH) || (state == ST_MEM);

  // Wait counter restarts whenever no request is pending or one completes.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (~mem_phase | mem_ready),
    .count_en (mem_phase & ~mem_ready),
    .expired  (wait_expired)
  );

  // State, latched opcode class, retire counter and sticky trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cls       <= CLS_R;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state     <= state_next;
      cls       <= cls_next;
      instret_q <= instret_next;
      trap_q    <= trap_next;
      cause_q   <= cause_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next   = state;
    cls_next     = cls;
    instret_next = instret_q;
    trap_next    = trap_q;
    cause_next   = cause_q;
    mem_ctl      = '0;
    ir_we        = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    retire       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_ctl.req      = 1'b1;
        mem_ctl.addr_sel = ADDR_SEL_PC;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          trap_next  = 1'b1;
          cause_next = CAUSE_FETCH_TO;
        end
      end
      ST_DECODE: begin
        if (is_legal(opcode)) begin
          cls_next   = op_class(opcode);
          state_next = ST_EXEC;
        end else begin
          state_next = ST_TRAP;
          trap_next  = 1'b1;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_R:                state_next = ST_WB;
          CLS_LOAD, CLS_STORE:  state_next = ST_MEM;
          CLS_BRANCH: begin
            pc_we  = 1'b1;
            pc_sel = alu_zero ? PC_SEL_BRANCH : PC_SEL_PLUS4;
            retire = 1'b1;
          end
          default:              state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_ctl.req      = 1'b1;
        mem_ctl.addr_sel = ADDR_SEL_ALU;
        mem_ctl.we       = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            mdr_we     = 1'b1;
            state_next = ST_WB;
          end
        end else if (wait_expired) begin
          state_next = ST_TRAP;
          trap_next  = 1'b1;
          cause_next = CAUSE_DATA_TO;
        end
      end
      ST_WB: begin
        rf_we  = 1'b1;
        wb_sel = (cls == CLS_LOAD) ? WB_SEL_MDR : WB_SEL_ALU;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (retire) begin
      instret_next = instret_q + CNT_W'(1);
      state_next   = run ? ST_FETCH : ST_IDLE;
    end
  end

  assign mem_req    = mem_ctl.req;
  assign mem_we     = mem_ctl.we;
  assign addr_sel   = mem_ctl.addr_sel;
  assign busy       = (state != ST_IDLE) && (state != ST_TRAP);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq with a reactive memory model and retire scoreboard.
module tb_multicycle_seq;

  localparam logic [6:0] T_ADD = 7'b0110011;
  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_BAD = 7'b1111111;

  logic       clk, rst_n, run, alu_zero, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, wb_sel, pc_we, pc_sel, busy, trap;
  logic [1:0] trap_cause;
  logic [3:0] instret;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int model_instret = 0;

  typedef struct {
    int         lat;
    int         rf;
    logic       wbs;
    logic       pcs;
    logic       mwe;
    int         mdr;
    int         dcyc;
    logic [3:0] ins;
  } exp_t;
  exp_t sb[$];

  multicycle_seq #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_sel(pc_sel), .busy(busy), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int base_lat(input logic [6:0] op);
    case (op)
      T_ADD:   return 4;
      T_LW:    return 5;
      T_SW:    return 4;
      default: return 3;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", {mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, wb_sel, pc_we, pc_sel, busy, trap}, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_instret", instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_instret = 0;
  endtask

  // One IDLE cycle with run raised; a stray mem_ready here must be ignored.
  task automatic start_run();
    @(negedge clk);
    run = 1'b1; mem_ready = 1'b1;
    #2;
    chk("idle_quiet", {mem_req, ir_we, mdr_we, rf_we, pc_we, busy}, 0);
  endtask

  // Drive one instruction from its first FETCH cycle to retire and score it.
  task automatic do_instr(input logic [6:0] op, input int fw, input int mw, input logic az,
                          input logic run_after, input logic noise);
    exp_t e, got;
    int lat, rf_n, mdr_n, ir_n, dcyc, nbusy, unstable, waits, ir_age;
    logic wbs, pcs, mwe, in_req, req_as, req_we, retired;
    logic is_mem;
    is_mem = (op == T_LW) || (op == T_SW);
    e.lat  = base_lat(op) + fw + (is_mem ? mw : 0);
    e.rf   = (op == T_ADD || op == T_LW) ? 1 : 0;
    e.wbs  = (op == T_LW);
    e.pcs  = (op == T_BEQ) && az;
    e.mwe  = (op == T_SW);
    e.mdr  = (op == T_LW) ? 1 : 0;
    e.dcyc = is_mem ? mw + 1 : 0;
    e.ins  = 4'((model_instret + 1) % 16);
    sb.push_back(e);

    opcode = op; alu_zero = az;
    lat = 0; rf_n = 0; mdr_n = 0; ir_n = 0; dcyc = 0; nbusy = 0; unstable = 0; waits = 0;
    ir_age = -1; wbs = 1'b0; pcs = 1'b0; mwe = 1'b0; in_req = 1'b0; req_as = 1'b0; req_we = 1'b0;
    retired = 1'b0;
    for (int cyc = 1; cyc <= 40 && !retired; cyc++) begin
      @(negedge clk);
      if (ir_age >= 0) ir_age++;
      if (ir_age == 2) begin
        opcode = T_BAD;
        run    = run_after;
      end
      #1;
      if (mem_req) begin
        if (!in_req) begin
          in_req = 1'b1; waits = addr_sel ? mw : fw; req_as = addr_sel; req_we = mem_we;
        end
        if (mem_we !== req_we || addr_sel !== req_as) unstable++;
        if (addr_sel) begin
          dcyc++;
          if (mem_we) mwe = 1'b1;
        end
        if (waits > 0) begin
          mem_ready = 1'b0; waits--;
        end else begin
          mem_ready = 1'b1; in_req = 1'b0;
        end
      end else begin
        mem_ready = noise;
      end
      #1;
      if (busy !== 1'b1) nbusy++;
      if (ir_we) begin ir_n++; ir_age = 0; end
      if (mdr_we) mdr_n++;
      if (rf_we) begin rf_n++; wbs = wb_sel; end
      if (pc_we) begin pcs = pc_sel; retired = 1'b1; lat = cyc; end
    end
    chk("retire_seen", retired, 1);
    got = sb.pop_front();
    chk("latency", lat, got.lat);
    chk("rf_we_pulses", rf_n, got.rf);
    if (got.rf != 0) chk("wb_sel", wbs, got.wbs);
    chk("pc_sel", pcs, got.pcs);
    chk("mem_we", mwe, got.mwe);
    chk("mdr_we_pulses", mdr_n, got.mdr);
    chk("ir_we_pulses", ir_n, 1);
    chk("data_req_cycles", dcyc, got.dcyc);
    chk("req_stable", unstable, 0);
    chk("busy_held", nbusy, 0);
    @(posedge clk);
    #1;
    chk("instret", instret, got.ins);
    chk("no_trap", trap, 0);
    model_instret = (model_instret + 1) % 16;
    if (!run_after) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #2;
      chk("idle_after_run0", {busy, mem_req, ir_we, pc_we}, 0);
    end
  endtask

  // Run until the trap flag appears, then confirm TRAP is absorbing.
  task automatic trap_run(input logic [6:0] op, input logic fetch_ok, input logic [1:0] cause,
                          input int exp_waits, input int exp_cyc);
    int waits, cyc_t, bad;
    logic hit;
    waits = 0; cyc_t = 0; bad = 0; hit = 1'b0;
    opcode = op; run = 1'b1;
    for (int c = 1; c <= 30 && !hit; c++) begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (!addr_sel && fetch_ok) mem_ready = 1'b1;
        else begin mem_ready = 1'b0; waits++; end
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (trap) begin hit = 1'b1; cyc_t = c; end
    end
    chk("trap_seen", hit, 1);
    chk("trap_cause", trap_cause, cause);
    chk("trap_wait_cycles", waits, exp_waits);
    chk("trap_cycle", cyc_t, exp_cyc);
    chk("trap_not_busy", busy, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mem_ready = 1'b1; run = 1'b1;
      #2;
      if (mem_req || ir_we || mdr_we || rf_we || pc_we || busy) bad++;
      if (trap !== 1'b1 || trap_cause !== cause) bad++;
    end
    chk("trap_absorbing", bad, 0);
  endtask

  // Assert reset asynchronously while a load waits in MEM.
  task automatic reset_mid_mem();
    int mem_cyc;
    logic done;
    mem_cyc = 0; done = 1'b0;
    opcode = T_LW; run = 1'b1;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (!addr_sel) mem_ready = 1'b1;
        else begin mem_ready = 1'b0; mem_cyc++; end
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (mem_cyc == 2) begin
        chk("mem_req_held", {mem_req, addr_sel}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_drops_req", mem_req, 0);
        chk("rst_instret", instret, 0);
        chk("rst_busy", busy, 0);
        done = 1'b1;
      end
    end
    chk("reached_mem", done, 1);
    do_reset();
  endtask

  initial begin
    logic [6:0] ops [4];
    ops[0] = T_ADD; ops[1] = T_BEQ; ops[2] = T_SW; ops[3] = T_LW;
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = '0;
    do_reset();

    start_run();
    do_instr(T_ADD, 0, 0, 1'b0, 1'b1, 1'b0);
    do_instr(T_LW,  0, 3, 1'b0, 1'b1, 1'b1);
    do_instr(T_BEQ, 0, 0, 1'b1, 1'b1, 1'b0);
    do_instr(T_BEQ, 1, 0, 1'b0, 1'b1, 1'b1);
    do_instr(T_SW,  0, 1, 1'b0, 1'b1, 1'b0);
    do_instr(T_ADD, 0, 0, 1'b0, 1'b0, 1'b1);

    start_run();
    for (int i = 0; i < 14; i++) begin
      do_instr(ops[i % 4], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    end
    do_instr(T_SW, 3, 3, 1'b0, 1'b1, 1'b0);
    reset_mid_mem();

    start_run();
    trap_run(T_BAD, 1'b1, 2'b01, 0, 3);
    do_reset();
    start_run();
    trap_run(T_ADD, 1'b0, 2'b10, 4, 5);
    do_reset();
    start_run();
    trap_run(T_LW, 1'b1, 2'b11, 4, 8);
    do_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
